// File: rtl/scaler_pkg.sv
// scaler_pkg: shared read-FSM state, position type and width helpers
// for the scaler2 horizontal/vertical pipeline.
package scaler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP,
      ST_DONE
   } rd_state_t;

   typedef logic [23:0] pos_t;

   function automatic int frac_bits(input int unit);
      return $clog2(unit);
   endfunction

   function automatic int acc_width(input int pw, input int cw);
      return pw + cw + 1;
   endfunction

endpackage

// File: rtl/scaler_h_linebuf.sv
// scaler_h_linebuf: ping-pong line store, one write port and two
// registered read ports on the bank selected by rbank.
module scaler_h_linebuf
   import scaler_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int PW    = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wbank,
   input  logic [AW-1:0] waddr,
   input  logic [PW-1:0] wdata,
   input  logic          rbank,
   input  logic [AW-1:0] raddr0,
   input  logic [AW-1:0] raddr1,
   output logic [PW-1:0] rdata0,
   output logic [PW-1:0] rdata1
);

   logic [PW-1:0] mem [2**(AW+1)];

   always_ff @(posedge clk) begin
      if (we) mem[{wbank, waddr}] <= wdata;
      rdata0 <= mem[{rbank, raddr0}];
      rdata1 <= mem[{rbank, raddr1}];
   end

endmodule

// File: rtl/scaler_h.sv
// scaler_h: horizontal linear-interpolation scaler, line-buffered.
// Define SCALER_H_ROUND_EN for round-half-up blending (else truncate).
module scaler_h
   import scaler_pkg::*;
#(
   parameter int LINE_IN_SIZE_MAX = 1024,
   parameter int SCALE_STEP       = 128,
   parameter int PIXEL_WIDTH      = 8,
   parameter int COE_WIDTH        = 8,
   parameter int SPARSE_OUT       = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            line_in_size,
   input  logic [15:0]            scale_step,
   input  logic [PIXEL_WIDTH-1:0] di_i,
   input  logic                   de_i,
   input  logic                   hs_i,
   input  logic                   vs_i,
   output logic [PIXEL_WIDTH-1:0] do_o,
   output logic                   de_o,
   output logic                   hs_o,
   output logic                   vs_o,
   output logic                   err_o
);

   localparam int F     = frac_bits(SCALE_STEP);
   localparam int AW    = $clog2(LINE_IN_SIZE_MAX);
   localparam int ACC   = acc_width(PIXEL_WIDTH, COE_WIDTH);
   localparam int CNT_W = 16;
   localparam logic [AW:0] MAXC = (AW+1)'(LINE_IN_SIZE_MAX);
   localparam logic [CNT_W-1:0] GAP_END = CNT_W'(SPARSE_OUT - 1);
   localparam logic [CNT_W-1:0] DRAIN = CNT_W'(3);
`ifdef SCALER_H_ROUND_EN
   localparam logic [ACC-1:0] RND = ACC'(1) << (COE_WIDTH - 1);
`else
   localparam logic [ACC-1:0] RND = '0;
`endif

   rd_state_t             state;
   pos_t                  pos;
   logic [CNT_W-1:0]      cnt;
   logic [15:0]           lsize;
   logic [15:0]           step;
   logic                  last;
   logic                  hs_d;
   logic                  vs_d;
   logic                  armed;
   logic                  wr_bank;
   logic [AW:0]           wr_cnt;
   logic                  s1_v, s1_end, s1_last;
   logic [COE_WIDTH-1:0]  s1_c;
   logic                  s2_v, s2_end, s2_last;
   logic [ACC-1:0]        m0, m1;
   logic                  rise, rise_last;
   logic [PIXEL_WIDTH-1:0] rdata0, rdata1;

   logic                  hs_rise;
   logic                  launch;
   logic                  we;
   pos_t                  pos_nx;
   pos_t                  idx;
   logic [AW-1:0]         raddr0, raddr1;
   logic [COE_WIDTH-1:0]  c_nx;
   logic [COE_WIDTH:0]    w0;
   logic [ACC-1:0]        sum;

   assign hs_rise = hs_i & ~hs_d;
   assign launch  = hs_rise & (wr_cnt != '0);
   assign we      = de_i & ~hs_i & armed & (wr_cnt < MAXC);
   assign pos_nx  = pos + pos_t'(step);
   assign idx     = pos >> F;
   assign raddr0  = AW'(idx);
   // right neighbour clamps to the last pixel of the line
   assign raddr1  = AW'((idx < pos_t'(lsize)) ? idx + 1'b1 : pos_t'(lsize));
   assign c_nx    = COE_WIDTH'(pos & pos_t'(SCALE_STEP - 1)) << (COE_WIDTH - F);
   assign w0      = {1'b1, {COE_WIDTH{1'b0}}} - {1'b0, s1_c};
   assign sum     = m0 + m1 + RND;

   scaler_h_linebuf #(
      .DEPTH (LINE_IN_SIZE_MAX),
      .PW    (PIXEL_WIDTH)
   ) u_buf (
      .clk    (clk),
      .we     (we),
      .wbank  (wr_bank),
      .waddr  (wr_cnt[AW-1:0]),
      .wdata  (di_i),
      .rbank  (~wr_bank),
      .raddr0 (raddr0),
      .raddr1 (raddr1),
      .rdata0 (rdata0),
      .rdata1 (rdata1)
   );

   // armed blocks a line that was already in progress when reset lifted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_d    <= 1'b1;
         vs_d    <= 1'b0;
         armed   <= 1'b0;
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         hs_d <= hs_i;
         vs_d <= vs_i;
         if (hs_i) armed <= 1'b1;
         if (hs_rise) wr_cnt <= '0;
         else if (we) wr_cnt <= wr_cnt + 1'b1;
         if (launch && state == ST_IDLE) wr_bank <= ~wr_bank;
         if (vs_i && !vs_d) err_o <= 1'b0;
         if (launch && state != ST_IDLE) err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pos     <= '0;
         cnt     <= '0;
         lsize   <= '0;
         step    <= '0;
         last    <= 1'b0;
         s1_v    <= 1'b0;
         s1_end  <= 1'b0;
         s1_last <= 1'b0;
         s1_c    <= '0;
      end else begin
         s1_v   <= 1'b0;
         s1_end <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               pos <= '0;
               cnt <= '0;
               if (launch) begin
                  lsize <= line_in_size;
                  step  <= scale_step;
                  last  <= ~vs_i;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               s1_v    <= 1'b1;
               s1_c    <= c_nx;
               s1_last <= last;
               pos     <= pos_nx;
               cnt     <= '0;
               if ((pos_nx >> F) > pos_t'(lsize)) begin
                  s1_end <= 1'b1;
                  state  <= ST_DONE;
               end else if (SPARSE_OUT != 0) begin
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt == GAP_END) begin
                  cnt   <= '0;
                  state <= ST_RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (cnt == DRAIN) state <= ST_IDLE;
               else cnt <= cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v      <= 1'b0;
         s2_end    <= 1'b0;
         s2_last   <= 1'b0;
         m0        <= '0;
         m1        <= '0;
         rise      <= 1'b0;
         rise_last <= 1'b0;
         do_o      <= '0;
         de_o      <= 1'b0;
         hs_o      <= 1'b1;
         vs_o      <= 1'b0;
      end else begin
         s2_v      <= s1_v;
         s2_end    <= s1_v & s1_end;
         s2_last   <= s1_last;
         m0        <= ACC'(rdata0) * ACC'(w0);
         m1        <= ACC'(rdata1) * ACC'(s1_c);
         de_o      <= s2_v;
         rise      <= s2_v & s2_end;
         rise_last <= s2_last;
         if (s2_v) begin
            do_o <= PIXEL_WIDTH'(sum >> COE_WIDTH);
            hs_o <= 1'b0;
            vs_o <= 1'b1;
         end
         if (rise) begin
            hs_o <= 1'b1;
            if (rise_last) vs_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scaler_h.sv
// tb_scaler_h: directed line/frame stimulus checked against a
// position-accumulator reference model of the horizontal scaler.
module tb_scaler_h;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [15:0] line_in_size = 16'd0;
   logic [15:0] scale_step = 16'd128;
   logic [7:0] di_i = '0;
   logic       de_i = 1'b0;
   logic       hs_i = 1'b1;
   logic       vs_i = 1'b0;
   logic [7:0] do_o, do_s;
   logic       de_o, hs_o, vs_o, err_o;
   logic       de_s, hs_s, vs_s, err_s;

`ifdef SCALER_H_ROUND_EN
   localparam int RND = 128;
   localparam int DOWN_PX1 = 14;
`else
   localparam int RND = 0;
   localparam int DOWN_PX1 = 13;
`endif

   always #5 clk = ~clk;

   scaler_h dut (
      .clk(clk), .rst_n(rst_n),
      .line_in_size(line_in_size), .scale_step(scale_step),
      .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
      .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
      .err_o(err_o)
   );

   scaler_h #(.SPARSE_OUT(1)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .line_in_size(line_in_size), .scale_step(scale_step),
      .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
      .do_o(do_s), .de_o(de_s), .hs_o(hs_s), .vs_o(vs_s),
      .err_o(err_s)
   );

   int n_pass = 0;
   int n_chk = 0;
   int cur [0:63];
   int ovr_exp [0:63];
   int last_px [0:63];
   int exp_q [$];
   int nline_q [$];
   int exp_sq [$];
   int exp_lines = -1;
   bit ovr_mode = 1'b0;
   bit sp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int n_out(input int lsize, input int step);
      return ((lsize + 1) * 128 - 1) / step + 1;
   endfunction

   // output k sits at k*step/128 input pixels; blend its two neighbours
   function automatic int blend(input int lsize, input int step, input int k);
      int pos, ix, fr, i1, w;
      pos = k * step;
      ix = pos / 128;
      fr = pos % 128;
      i1 = (ix + 1 > lsize) ? lsize : ix + 1;
      w = fr * 2;
      return (cur[ix] * (256 - w) + cur[i1] * w + RND) / 256;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int kind, input int y);
      for (int x = 0; x < 64; x++)
         cur[x] = (kind == 0) ? ((x * 8 + y * 3) & 255) : ((x * 10) & 255);
   endtask

   task automatic push_line(input int lsize, input int step);
      int n;
      n = n_out(lsize, step);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(blend(lsize, step, k));
         if (sp_en) exp_sq.push_back(blend(lsize, step, k));
      end
      nline_q.push_back(n);
   endtask

   task automatic drive_line(input int n, input int blank, input bit last_line);
      hs_i = 1'b0;
      vs_i = 1'b1;
      for (int x = 0; x < n; x++) begin
         de_i = 1'b1;
         di_i = 8'(cur[x]);
         tick();
      end
      de_i = 1'b0;
      hs_i = 1'b1;
      if (last_line) vs_i = 1'b0;
      repeat (blank) tick();
   endtask

   task automatic run_frame(input int lines, input int kind, input int lsize,
                            input int step, input int blank);
      line_in_size = 16'(lsize);
      scale_step = 16'(step);
      exp_lines = lines;
      for (int y = 0; y < lines; y++) begin
         fill(kind, y);
         push_line(lsize, step);
         drive_line(lsize + 1, blank, y == lines - 1);
      end
      repeat (60) tick();
      check("pixels_drained", exp_q.size(), 0);
      check("lines_drained", nline_q.size(), 0);
   endtask

   int pidx = 0, hcnt = 0;
   logic ph = 1'b1, pv = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pidx = 0;
         hcnt = 0;
         ph = 1'b1;
         pv = 1'b0;
      end else begin
         if (de_o) begin
            check("de_framing", int'({hs_o, vs_o}), 1);
            if (pidx < 64) last_px[pidx] = do_o;
            if (ovr_mode) check("ovr_pixel", do_o, ovr_exp[pidx]);
            else check("pixel", do_o, exp_q.size() != 0 ? exp_q.pop_front() : -1);
            pidx++;
         end
         if (ph && !hs_o) hcnt++;
         if (!ph && hs_o) begin
            if (ovr_mode) check("ovr_line_len", pidx, 24);
            else check("line_len", pidx,
                       nline_q.size() != 0 ? nline_q.pop_front() : -1);
            pidx = 0;
         end
         if (pv && !vs_o) begin
            check("vs_fall_with_hs_rise", int'(!ph && hs_o), 1);
            if (exp_lines >= 0) check("frame_lines", hcnt, exp_lines);
            hcnt = 0;
         end
         ph = hs_o;
         pv = vs_o;
      end
   end

   int scnt = 0;
   logic sph = 1'b1, spd = 1'b0;

   always @(negedge clk) begin
      if (rst_n && sp_en) begin
         if (!hs_s && !sph) check("sparse_alternate", int'(de_s), int'(!spd));
         if (de_s) begin
            check("sparse_pixel", do_s, exp_sq.size() != 0 ? exp_sq.pop_front() : -1);
            scnt++;
         end
         if (!sph && hs_s) begin
            check("sparse_line_len", scnt, 24);
            scnt = 0;
         end
      end else begin
         scnt = 0;
      end
      sph = hs_s;
      spd = de_s;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_do", do_o, 0);
      check("rst_de", de_o, 0);
      check("rst_hs", hs_o, 1);
      check("rst_vs", vs_o, 0);
      check("rst_err", err_o, 0);
      rst_n = 1'b1;
      repeat (3) tick();

      check("model_n_ident", n_out(23, 128), 24);
      check("model_n_down", n_out(23, 179), 18);
      check("model_n_up", n_out(23, 64), 48);

      run_frame(24, 0, 23, 128, 10);
      check("ident_px5", last_px[5], cur[5]);
      check("ident_px23", last_px[23], cur[23]);

      fill(1, 0);
      check("model_down_px1", blend(23, 179, 1), DOWN_PX1);
      check("model_up_px3", blend(23, 64, 3), 15);
      run_frame(2, 1, 23, 179, 40);
      check("down_px0", last_px[0], 0);
      check("down_px1", last_px[1], DOWN_PX1);

      run_frame(2, 1, 23, 64, 40);
      check("up_px1", last_px[1], 5);
      check("up_px3", last_px[3], 15);
      check("up_px46", last_px[46], 230);
      check("up_px47", last_px[47], 230);

      sp_en = 1'b1;
      run_frame(2, 0, 23, 128, 60);
      check("sparse_drained", exp_sq.size(), 0);
      sp_en = 1'b0;

      fill(1, 0);
      for (int k = 0; k < 24; k++) ovr_exp[k] = blend(11, 64, k);
      ovr_mode = 1'b1;
      exp_lines = -1;
      line_in_size = 16'd11;
      scale_step = 16'd64;
      for (int y = 0; y < 5; y++) begin
         drive_line(12, 8, y == 4);
         if (y == 2) check("err_set", err_o, 1);
      end
      repeat (60) tick();
      check("err_sticky", err_o, 1);
      ovr_mode = 1'b0;
      vs_i = 1'b1;
      tick();
      tick();
      check("err_clear", err_o, 0);

      line_in_size = 16'd23;
      scale_step = 16'd128;
      fill(1, 0);
      push_line(23, 128);
      drive_line(24, 0, 1'b0);
      repeat (8) tick();
      check("mid_output_de", de_o, 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_do", do_o, 0);
      check("arst_de", de_o, 0);
      check("arst_hs", hs_o, 1);
      check("arst_vs", vs_o, 0);
      check("arst_err", err_o, 0);
      exp_q.delete();
      nline_q.delete();
      vs_i = 1'b0;
      hs_i = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      run_frame(2, 0, 23, 179, 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
